// File: rtl/step_seq_pkg.sv
// Shared constants and encodings for the step-sequencer grid cursor.
package step_seq_pkg;

   localparam int GRID_N = 12;
   localparam int PITCH  = 33;
   localparam int X0     = 214;
   localparam int Y0     = 32;

   typedef enum logic [2:0] {
      INIT_HI, INIT_LO, IDLE, REQ, WAIT_HI, WAIT_LO
   } fsm_e;

   typedef enum logic [2:0] {
      DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT
   } dir_e;

   // Collapse simultaneous button pulses to one move: up > down > left > right.
   function automatic dir_e pick_dir(input logic up, input logic down,
                                     input logic left, input logic right);
      if (up)         return DIR_UP;
      else if (down)  return DIR_DOWN;
      else if (left)  return DIR_LEFT;
      else if (right) return DIR_RIGHT;
      else            return DIR_NONE;
   endfunction

   function automatic logic [9:0] pix_x(input logic [3:0] col);
      return 10'(X0) + 10'(col) * 10'(PITCH);
   endfunction

   function automatic logic [8:0] pix_y(input logic [3:0] row);
      return 9'(Y0) + 9'(row) * 9'(PITCH);
   endfunction

endpackage

// File: rtl/draw_done_det.sv
// Watches the vga_display busy flag: reports it high, and reports completion
// only after two consecutive low samples so the one-cycle dip between the
// cursor and box phases is never mistaken for the end of a draw.
module draw_done_det (
   input  logic clk,
   input  logic rst_n,
   input  logic drawing,
   output logic high,
   output logic done
);
   logic low_q;

   // Remember whether the previous edge sampled drawing low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) low_q <= 1'b0;
      else        low_q <= ~drawing;
   end

   assign high = drawing;
   assign done = ~drawing & low_q;
endmodule

// File: rtl/grid_cursor_ctrl.sv
// Cursor/pattern owner for the 12x12 step grid; initiator of draw requests
// toward vga_display.
module grid_cursor_ctrl
   import step_seq_pkg::*;
(
   input  logic         CLOCK_50,
   input  logic         nReset,
   input  logic         btn_up,
   input  logic         btn_down,
   input  logic         btn_left,
   input  logic         btn_right,
   input  logic         btn_toggle,
   input  logic         drawing,
   output logic         draw_enable,
   output logic [9:0]   X,
   output logic [8:0]   Y,
   output logic [9:0]   OLD_X,
   output logic [8:0]   OLD_Y,
   output logic         state,
   output logic [3:0]   cursor_col,
   output logic [3:0]   cursor_row,
   output logic [143:0] pattern
);
   localparam logic [3:0] LAST = 4'(GRID_N - 1);

   fsm_e         fsm;
   dir_e         pend;
   dir_e         fresh_dir;
   dir_e         mv_dir;
   logic         drw_high;
   logic         drw_done;
   logic         toggle_en;
   logic [7:0]   cur_idx;
   logic [143:0] pat_tog;
   logic [3:0]   nxt_col;
   logic [3:0]   nxt_row;

   draw_done_det u_done (
      .clk     (CLOCK_50),
      .rst_n   (nReset),
      .drawing (drawing),
      .high    (drw_high),
      .done    (drw_done)
   );

   // A fresh pulse outranks (and discards) an older pending move.
   assign fresh_dir = pick_dir(btn_up, btn_down, btn_left, btn_right);
   assign mv_dir    = (fresh_dir != DIR_NONE) ? fresh_dir : pend;

   // Toggles are dropped while the initial full-screen draw is running.
   assign toggle_en = btn_toggle && (fsm != INIT_HI) && (fsm != INIT_LO);
   assign cur_idx   = 8'(cursor_row) * 8'(GRID_N) + 8'(cursor_col);
   assign pat_tog   = toggle_en ? (pattern ^ (144'(1) << cur_idx)) : pattern;

   // Next cursor cell with wrap-around at both grid edges.
   always_comb begin
      nxt_col = cursor_col;
      nxt_row = cursor_row;
      case (mv_dir)
         DIR_UP:    nxt_row = (cursor_row == 4'd0) ? LAST : cursor_row - 4'd1;
         DIR_DOWN:  nxt_row = (cursor_row == LAST) ? 4'd0 : cursor_row + 4'd1;
         DIR_LEFT:  nxt_col = (cursor_col == 4'd0) ? LAST : cursor_col - 4'd1;
         DIR_RIGHT: nxt_col = (cursor_col == LAST) ? 4'd0 : cursor_col + 4'd1;
         default:   ;
      endcase
   end

   // Handshake FSM, pattern register, pending move and registered draw outputs.
   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         fsm         <= INIT_HI;
         pend        <= DIR_NONE;
         draw_enable <= 1'b0;
         cursor_col  <= 4'd0;
         cursor_row  <= 4'd0;
         X           <= 10'(X0);
         Y           <= 9'(Y0);
         OLD_X       <= 10'(X0);
         OLD_Y       <= 9'(Y0);
         state       <= 1'b0;
         pattern     <= '0;
      end else begin
         draw_enable <= 1'b0;
         if (toggle_en) pattern <= pat_tog;
         case (fsm)
            INIT_HI: if (drw_high) fsm <= INIT_LO;
            INIT_LO: if (drw_done) fsm <= IDLE;
            IDLE: begin
               if (mv_dir != DIR_NONE) begin
                  OLD_X       <= X;
                  OLD_Y       <= Y;
                  state       <= pat_tog[cur_idx];
                  cursor_col  <= nxt_col;
                  cursor_row  <= nxt_row;
                  X           <= pix_x(nxt_col);
                  Y           <= pix_y(nxt_row);
                  pend        <= DIR_NONE;
                  draw_enable <= 1'b1;
                  fsm         <= REQ;
               end
            end
            REQ: begin
               if (fresh_dir != DIR_NONE) pend <= fresh_dir;
               fsm <= WAIT_HI;
            end
            WAIT_HI: begin
               if (fresh_dir != DIR_NONE) pend <= fresh_dir;
               if (drw_high) fsm <= WAIT_LO;
            end
            WAIT_LO: begin
               if (fresh_dir != DIR_NONE) pend <= fresh_dir;
               if (drw_done) fsm <= IDLE;
            end
            default: fsm <= INIT_HI;
         endcase
      end
   end
endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Directed bench for grid_cursor_ctrl with hand-computed pixel coordinates.
module tb_grid_cursor_ctrl;
   logic         CLOCK_50 = 1'b0;
   logic         nReset = 1'b0;
   logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic         btn_toggle = 1'b0;
   logic         drawing = 1'b0;
   logic         draw_enable;
   logic [9:0]   X, OLD_X;
   logic [8:0]   Y, OLD_Y;
   logic         state;
   logic [3:0]   cursor_col, cursor_row;
   logic [143:0] pattern;

   int checks = 0;
   int errors = 0;

   grid_cursor_ctrl dut (
      .CLOCK_50    (CLOCK_50),
      .nReset      (nReset),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_toggle  (btn_toggle),
      .drawing     (drawing),
      .draw_enable (draw_enable),
      .X           (X),
      .Y           (Y),
      .OLD_X       (OLD_X),
      .OLD_Y       (OLD_Y),
      .state       (state),
      .cursor_col  (cursor_col),
      .cursor_row  (cursor_row),
      .pattern     (pattern)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // One clock edge; inputs change and outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic clr_btn();
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_toggle = 0;
   endtask

   // Called right after a request was observed: complete a normal draw.
   task automatic finish_draw(input string tag);
      clr_btn();
      drawing = 1;
      step();
      chk({tag, "_de_one"}, draw_enable, 1'b0);
      step();
      drawing = 0;
      step();
      step();
   endtask

   task automatic pulse_move(input int dir);
      btn_up    = (dir == 0);
      btn_down  = (dir == 1);
      btn_left  = (dir == 2);
      btn_right = (dir == 3);
      step();
      clr_btn();
   endtask

   initial begin
      int de_cnt;
      int de_at;
      logic [3:0] row_at;
      logic [8:0] y_at, oy_at;
      logic [9:0] x_at, ox_at;

      // Reset state
      repeat (3) step();
      chk("rst_de", draw_enable, 1'b0);
      chk("rst_x", X, 214);
      chk("rst_y", Y, 32);
      chk("rst_ox", OLD_X, 214);
      chk("rst_oy", OLD_Y, 32);
      chk("rst_state", state, 1'b0);
      chk("rst_pat", pattern, 0);
      chk("rst_cur", {cursor_row, cursor_col}, 8'h00);
      nReset = 1;
      step();

      // INIT_HI ignores moves and drops toggles
      btn_right = 1; btn_toggle = 1;
      step();
      clr_btn();
      step();
      chk("init_move_ign", cursor_col, 4'd0);
      chk("init_tog_drop", pattern, 0);
      chk("init_no_de", draw_enable, 1'b0);

      // Startup full redraw
      de_cnt = 0;
      drawing = 1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (draw_enable) de_cnt++;
      end
      drawing = 0;
      btn_right = 1;            // lands on the first low sample: still INIT_LO
      step();
      if (draw_enable) de_cnt++;
      clr_btn();
      step();                   // second low sample: now IDLE
      if (draw_enable) de_cnt++;
      chk("start_no_de", de_cnt, 0);
      chk("start_col", cursor_col, 4'd0);
      chk("start_x", X, 214);
      chk("start_y", Y, 32);

      // Right from (0,0)
      pulse_move(3);
      chk("r_de", draw_enable, 1'b1);
      chk("r_x", X, 247);
      chk("r_y", Y, 32);
      chk("r_ox", OLD_X, 214);
      chk("r_oy", OLD_Y, 32);
      chk("r_state", state, 1'b0);
      finish_draw("r");

      // Left back to col 0, then wrap left to col 11
      pulse_move(2);
      chk("l1_x", X, 214);
      chk("l1_ox", OLD_X, 247);
      finish_draw("l1");
      pulse_move(2);
      chk("lw_col", cursor_col, 4'd11);
      chk("lw_x", X, 577);
      chk("lw_ox", OLD_X, 214);
      finish_draw("lw");

      // Up wraps row 0 -> 11
      pulse_move(0);
      chk("uw_row", cursor_row, 4'd11);
      chk("uw_y", Y, 395);
      chk("uw_oy", OLD_Y, 32);
      chk("uw_x", X, 577);
      finish_draw("uw");

      // Down and right wrap back to (0,0)
      pulse_move(1);
      chk("dw_row", cursor_row, 4'd0);
      chk("dw_y", Y, 32);
      finish_draw("dw");
      pulse_move(3);
      chk("rw_col", cursor_col, 4'd0);
      chk("rw_x", X, 214);
      chk("rw_ox", OLD_X, 577);
      finish_draw("rw");

      // Toggle at (0,0): pattern bit set, no request
      btn_toggle = 1;
      step();
      clr_btn();
      chk("tog_pat", pattern, 1);
      chk("tog_no_de", draw_enable, 1'b0);
      step();
      chk("tog_no_de2", draw_enable, 1'b0);
      pulse_move(3);
      chk("tog_state", state, 1'b1);
      chk("tog_ox", OLD_X, 214);
      chk("tog_de", draw_enable, 1'b1);
      finish_draw("tr");
      pulse_move(2);
      chk("back_state", state, 1'b0);
      finish_draw("bk");

      // Toggle + right together from (0,0) with pattern[0]=1
      btn_toggle = 1; btn_right = 1;
      step();
      clr_btn();
      chk("tr_pat", pattern, 0);
      chk("tr_state", state, 1'b0);
      chk("tr_col", cursor_col, 4'd1);
      chk("tr_de", draw_enable, 1'b1);
      finish_draw("tr2");

      // Busy draw with a one-cycle dip; two moves arrive mid-draw
      pulse_move(3);            // (1,0) -> (2,0), REQ
      chk("busy_req", draw_enable, 1'b1);
      de_cnt = 0; de_at = -1;
      row_at = 0; y_at = 0; oy_at = 0; x_at = 0; ox_at = 0;
      for (int i = 0; i < 1943; i++) begin
         drawing  = (i < 961) || (i >= 962 && i < 1923);
         btn_down = (i == 100) || (i == 1100);
         step();
         if (draw_enable) begin
            de_cnt++;
            de_at  = i;
            row_at = cursor_row;
            y_at   = Y;
            oy_at  = OLD_Y;
            x_at   = X;
            ox_at  = OLD_X;
         end
      end
      btn_down = 0;
      chk("busy_cnt", de_cnt, 1);
      chk("busy_at", de_at, 1925);
      chk("busy_row", row_at, 4'd1);
      chk("busy_y", y_at, 65);
      chk("busy_oy", oy_at, 32);
      chk("busy_x", x_at, 280);
      chk("busy_ox", ox_at, 280);

      // Now in WAIT_HI at (2,1): toggle there, then reset mid-draw
      btn_toggle = 1;
      step();
      btn_toggle = 0;
      chk("wait_tog", pattern, 144'(1) << 14);
      nReset = 0;
      #1;
      chk("mid_rst_de", draw_enable, 1'b0);
      chk("mid_rst_cur", {cursor_row, cursor_col}, 8'h00);
      chk("mid_rst_pat", pattern, 0);
      chk("mid_rst_x", X, 214);
      step();
      nReset = 1;
      drawing = 0;
      repeat (4) step();
      pulse_move(3);
      chk("rst_hold_de", draw_enable, 1'b0);
      chk("rst_hold_col", cursor_col, 4'd0);
      drawing = 1;
      step();
      drawing = 0;
      step();
      step();
      pulse_move(3);
      chk("rst_resume_de", draw_enable, 1'b1);
      chk("rst_resume_x", X, 247);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
